// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone cache bridge.
//   state_e   : bridge controller states
//   SZ_*      : non-cacheable access size encodings (log2 of byte count)
//   lane_sel  : byte-lane select for a given size and byte offset within the bus word
package wb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BLK_RD = 3'd1,
    BLK_WR = 3'd2,
    NC_RD  = 3'd3,
    NC_WR  = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Contiguous run of 2^size ones, shifted up to the starting byte lane.
  // Sized for the widest (64-bit) bus; callers truncate to their lane count.
  function automatic logic [7:0] lane_sel(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] run;
    case (size)
      SZ_BYTE: run = 8'h01;
      SZ_HALF: run = 8'h03;
      SZ_WORD: run = 8'h0F;
      default: run = 8'hFF;
    endcase
    return run << off;
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Combinational byte-lane alignment for non-cacheable accesses.
//   off_i      : byte offset of the access inside the bus word
//   size_i     : access size (SZ_BYTE..SZ_DWORD)
//   wdata_i    : LSB-justified write data
//   rdata_i    : raw bus read word
//   sel_o      : byte-lane select
//   wdata_o    : write data moved onto its byte lanes
//   rdata_o    : read data moved down to bit 0 and zero-extended above the access size
//   misalign_o : access is not naturally aligned, or is wider than the bus
module wb_lane_align
  import wb_bridge_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  localparam int LANES      = DATA_WIDTH / 8,
  localparam int OFFS       = $clog2(LANES)
) (
  input  logic [OFFS-1:0]       off_i,
  input  logic [1:0]            size_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [LANES-1:0]      sel_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misalign_o
);

  logic [2:0]            off3;
  logic [LANES-1:0]      keep;
  logic [DATA_WIDTH-1:0] rd_shifted;

  assign off3 = 3'(off_i);

  assign sel_o   = LANES'(lane_sel(size_i, off3));
  assign wdata_o = wdata_i << {off_i, 3'b000};

  // Byte lanes that survive the read mask: the same run of ones, unshifted.
  assign keep       = LANES'(lane_sel(size_i, 3'd0));
  assign rd_shifted = rdata_i >> {off_i, 3'b000};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_rd_lane
    assign rdata_o[gi*8 +: 8] = keep[gi] ? rd_shifted[gi*8 +: 8] : 8'h00;
  end

  // A dword can never be carried by a 32-bit bus, whatever its alignment.
  always_comb begin
    case (size_i)
      SZ_BYTE: misalign_o = 1'b0;
      SZ_HALF: misalign_o = off3[0];
      SZ_WORD: misalign_o = |off3[1:0];
      default: misalign_o = (DATA_WIDTH == 32) || (|off3);
    endcase
  end

endmodule

// File: rtl/wb_cache_bridge.sv
// Bridge between the CPU datapath and a Wishbone-style memory bus.
// Block refills/write-backs are serialised into BEATS single-word beats;
// non-cacheable accesses are issued as one lane-aligned beat. Completion is a
// one-cycle o_done pulse, with o_err qualifying it.
//   clk, arst                     : clock, asynchronous active-high reset
//   i_blk_rd_req / i_blk_wr_req   : block refill / write-back request (level)
//   i_blk_addr, i_blk_wdata       : block address and write-back block
//   o_blk_rdata                   : refilled block
//   i_nc_rd_req / i_nc_wr_req     : non-cacheable read / write request (level)
//   i_nc_addr, i_nc_size          : byte address and access size
//   i_nc_wdata, o_nc_rdata        : LSB-justified write / read data
//   o_done, o_err                 : completion pulse and error flag
//   o_wb_* / i_wb_*               : bus master interface
module wb_cache_bridge
  import wb_bridge_pkg::*;
#(
  parameter int  ADDR_WIDTH  = 32,
  parameter int  DATA_WIDTH  = 32,
  parameter int  BLOCK_WIDTH = 512,
  localparam int BEATS       = BLOCK_WIDTH / DATA_WIDTH,
  localparam int LANES       = DATA_WIDTH / 8,
  localparam int OFFS        = $clog2(LANES),
  localparam int CNT_W       = $clog2(BEATS),
  localparam int BOFF        = $clog2(BLOCK_WIDTH / 8)
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   i_blk_rd_req,
  input  logic                   i_blk_wr_req,
  input  logic [ADDR_WIDTH-1:0]  i_blk_addr,
  input  logic [BLOCK_WIDTH-1:0] i_blk_wdata,
  output logic [BLOCK_WIDTH-1:0] o_blk_rdata,
  input  logic                   i_nc_rd_req,
  input  logic                   i_nc_wr_req,
  input  logic [ADDR_WIDTH-1:0]  i_nc_addr,
  input  logic [1:0]             i_nc_size,
  input  logic [DATA_WIDTH-1:0]  i_nc_wdata,
  output logic [DATA_WIDTH-1:0]  o_nc_rdata,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_wb_cyc,
  output logic                   o_wb_we,
  output logic [LANES-1:0]       o_wb_sel,
  output logic [ADDR_WIDTH-1:0]  o_wb_addr,
  output logic [DATA_WIDTH-1:0]  o_wb_wdata,
  input  logic [DATA_WIDTH-1:0]  i_wb_rdata,
  input  logic                   i_wb_ack,
  input  logic                   i_wb_err
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [1:0]             size_q, size_d;
  logic [DATA_WIDTH-1:0]  nc_wdata_q, nc_wdata_d;
  logic [BLOCK_WIDTH-1:0] blk_wdata_q, blk_wdata_d;
  logic                   err_q, err_d;
  logic [BLOCK_WIDTH-1:0] blk_rdata_q, blk_rdata_d;
  logic [DATA_WIDTH-1:0]  nc_rdata_q, nc_rdata_d;
  logic                   beat_we;

  // Lane unit is shared: in IDLE it judges the incoming request for
  // misalignment, afterwards it serves the captured access.
  logic [OFFS-1:0]        al_off;
  logic [1:0]             al_size;
  logic [LANES-1:0]       al_sel;
  logic [DATA_WIDTH-1:0]  al_wdata;
  logic [DATA_WIDTH-1:0]  al_rdata;
  logic                   al_misalign;

  assign al_off  = (state_q == IDLE) ? i_nc_addr[OFFS-1:0] : addr_q[OFFS-1:0];
  assign al_size = (state_q == IDLE) ? i_nc_size : size_q;

  wb_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .off_i      (al_off),
    .size_i     (al_size),
    .wdata_i    (nc_wdata_q),
    .rdata_i    (i_wb_rdata),
    .sel_o      (al_sel),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign)
  );

  // Captured write-back block viewed as an array of beats.
  logic [DATA_WIDTH-1:0] wbeat [BEATS];
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_wbeat
    assign wbeat[gi] = blk_wdata_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [ADDR_WIDTH-1:0] blk_base;
  assign blk_base = {addr_q[ADDR_WIDTH-1:BOFF], {BOFF{1'b0}}};

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    nc_wdata_d  = nc_wdata_q;
    blk_wdata_d = blk_wdata_q;
    err_d       = err_q;
    nc_rdata_d  = nc_rdata_q;
    beat_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_blk_wr_req || i_blk_rd_req) begin
          addr_d      = i_blk_addr;
          blk_wdata_d = i_blk_wdata;
          cnt_d       = '0;
          err_d       = 1'b0;
          state_d     = i_blk_wr_req ? BLK_WR : BLK_RD;
        end else if (i_nc_wr_req || i_nc_rd_req) begin
          addr_d     = i_nc_addr;
          size_d     = i_nc_size;
          nc_wdata_d = i_nc_wdata;
          err_d      = al_misalign;
          if (al_misalign) begin
            state_d = DONE;
          end else begin
            state_d = i_nc_wr_req ? NC_WR : NC_RD;
          end
        end
      end

      BLK_RD, BLK_WR: begin
        // An error terminates the beat even when ack is raised alongside it.
        if (i_wb_err) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else if (i_wb_ack) begin
          beat_we = (state_q == BLK_RD);
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      NC_RD, NC_WR: begin
        if (i_wb_err) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (i_wb_ack) begin
          if (state_q == NC_RD) begin
            nc_rdata_d = al_rdata;
          end
          err_d   = 1'b0;
          state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Refill data lands in the slice addressed by the beat counter.
  always_comb begin
    blk_rdata_d = blk_rdata_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_we && (cnt_q == CNT_W'(b))) begin
        blk_rdata_d[b*DATA_WIDTH +: DATA_WIDTH] = i_wb_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      nc_wdata_q  <= '0;
      blk_wdata_q <= '0;
      err_q       <= 1'b0;
      blk_rdata_q <= '0;
      nc_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      nc_wdata_q  <= nc_wdata_d;
      blk_wdata_q <= blk_wdata_d;
      err_q       <= err_d;
      blk_rdata_q <= blk_rdata_d;
      nc_rdata_q  <= nc_rdata_d;
    end
  end

  // Bus outputs are held at zero outside the bus states.
  always_comb begin
    o_wb_cyc   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_sel   = '0;
    o_wb_addr  = '0;
    o_wb_wdata = '0;
    case (state_q)
      BLK_RD, BLK_WR: begin
        o_wb_cyc   = 1'b1;
        o_wb_we    = (state_q == BLK_WR);
        o_wb_sel   = '1;
        o_wb_addr  = blk_base + (ADDR_WIDTH'(cnt_q) << OFFS);
        o_wb_wdata = wbeat[cnt_q];
      end
      NC_RD, NC_WR: begin
        o_wb_cyc   = 1'b1;
        o_wb_we    = (state_q == NC_WR);
        o_wb_sel   = al_sel;
        o_wb_addr  = {addr_q[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
        o_wb_wdata = al_wdata;
      end
      default: ;
    endcase
  end

  assign o_done      = (state_q == DONE);
  assign o_err       = (state_q == DONE) && err_q;
  assign o_blk_rdata = blk_rdata_q;
  assign o_nc_rdata  = nc_rdata_q;

endmodule

// File: tb/tb_wb_cache_bridge.sv
`timescale 1ns/1ps
module tb_wb_cache_bridge;
  localparam int AW = 32, DW = 32, BW = 512, BEATS = 16, LANES = 4;
  localparam int K_BR = 0, K_BW = 1, K_NR = 2, K_NW = 3;
  localparam int P_IDLE = 0, P_BUS = 1, P_DONE = 2;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic i_blk_rd_req, i_blk_wr_req, i_nc_rd_req, i_nc_wr_req;
  logic [AW-1:0] i_blk_addr, i_nc_addr;
  logic [BW-1:0] i_blk_wdata, o_blk_rdata;
  logic [1:0] i_nc_size;
  logic [DW-1:0] i_nc_wdata, o_nc_rdata;
  logic o_done, o_err, o_wb_cyc, o_wb_we;
  logic [LANES-1:0] o_wb_sel;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_wdata, i_wb_rdata;
  logic i_wb_ack, i_wb_err;

  always #5 clk = ~clk;

  wb_cache_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) dut (
    .clk(clk), .arst(arst),
    .i_blk_rd_req(i_blk_rd_req), .i_blk_wr_req(i_blk_wr_req),
    .i_blk_addr(i_blk_addr), .i_blk_wdata(i_blk_wdata), .o_blk_rdata(o_blk_rdata),
    .i_nc_rd_req(i_nc_rd_req), .i_nc_wr_req(i_nc_wr_req), .i_nc_addr(i_nc_addr),
    .i_nc_size(i_nc_size), .i_nc_wdata(i_nc_wdata), .o_nc_rdata(o_nc_rdata),
    .o_done(o_done), .o_err(o_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .o_wb_addr(o_wb_addr), .o_wb_wdata(o_wb_wdata),
    .i_wb_rdata(i_wb_rdata), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus slave responder ----------------
  int ack_period = 1;
  int err_beat = -1;
  logic [31:0] rd_base = 32'h0;

  initial begin
    int wcnt;
    int rbeat;
    wcnt = 0;
    rbeat = 0;
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    i_wb_rdata = '0;
    forever begin
      @(negedge clk);
      if (i_wb_ack) rbeat++;
      if (!o_wb_cyc || arst) begin
        wcnt = 0; rbeat = 0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
      end else begin
        wcnt++;
        if (wcnt % ack_period == 0) begin
          if (rbeat == err_beat) begin i_wb_err = 1'b1; i_wb_ack = 1'b0; end
          else begin i_wb_ack = 1'b1; i_wb_err = 1'b0; end
        end else begin
          i_wb_ack = 1'b0; i_wb_err = 1'b0;
        end
        i_wb_rdata = rd_base + 32'(rbeat);
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  int          m_ph, m_kind, m_beat;
  logic [31:0] m_addr, m_ncw, m_nc;
  logic [1:0]  m_size;
  logic [BW-1:0] m_bw;
  logic        m_err;
  logic [31:0] m_blk [BEATS];
  bit          m_init = 1'b0;

  task automatic model_reset();
    m_ph = P_IDLE; m_kind = 0; m_beat = 0; m_addr = 0; m_ncw = 0; m_nc = 0;
    m_size = 0; m_bw = '0; m_err = 1'b0;
    for (int i = 0; i < BEATS; i++) m_blk[i] = 32'h0;
  endtask

  function automatic logic [31:0] nc_mask(input logic [1:0] s);
    logic [63:0] m;
    m = (64'd1 << (8 * (1 << s))) - 64'd1;
    return m[31:0];
  endfunction

  task automatic model_step();
    int k;
    case (m_ph)
      P_IDLE: begin
        k = -1;
        if (i_blk_wr_req) k = K_BW;
        else if (i_blk_rd_req) k = K_BR;
        else if (i_nc_wr_req) k = K_NW;
        else if (i_nc_rd_req) k = K_NR;
        if (k >= 0) begin
          m_kind = k; m_beat = 0; m_err = 1'b0;
          if (k == K_BR || k == K_BW) begin
            m_addr = i_blk_addr - (i_blk_addr % 64);
            m_bw = i_blk_wdata;
            m_ph = P_BUS;
          end else begin
            m_addr = i_nc_addr; m_size = i_nc_size; m_ncw = i_nc_wdata;
            if (i_nc_size == 2'd3 || (i_nc_addr % (1 << i_nc_size)) != 0) begin
              m_ph = P_DONE; m_err = 1'b1;
            end else m_ph = P_BUS;
          end
        end
      end
      P_BUS: begin
        if (i_wb_err) begin
          m_ph = P_DONE; m_err = 1'b1;
        end else if (i_wb_ack) begin
          if (m_kind == K_BR) m_blk[m_beat] = i_wb_rdata;
          if (m_kind == K_NR) m_nc = (i_wb_rdata >> (8 * m_addr[1:0])) & nc_mask(m_size);
          m_beat++;
          if (m_kind == K_NR || m_kind == K_NW || m_beat == BEATS) m_ph = P_DONE;
        end
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  initial begin
    model_reset();
    m_init = 1'b1;
    forever begin
      @(posedge clk or posedge arst);
      if (arst) model_reset();
      else model_step();
    end
  end

  function automatic logic [BW-1:0] blk_vec();
    logic [BW-1:0] v;
    for (int i = 0; i < BEATS; i++) v[i*32 +: 32] = m_blk[i];
    return v;
  endfunction

  // ---------------- per-cycle compare + observation ----------------
  logic [31:0] first_addr, last_addr, last_wdata;
  logic [3:0]  last_sel;
  int cyc_cnt = 0, done_cnt = 0;
  logic prev_cyc = 1'b0;

  initial begin
    logic [31:0] ea, ew;
    logic [3:0] es;
    wait (m_init);
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("cyc", o_wb_cyc, m_ph == P_BUS);
      check("done", o_done, m_ph == P_DONE);
      check("err", o_err, m_ph == P_DONE && m_err);
      check("blk_rdata", o_blk_rdata, blk_vec());
      check("nc_rdata", o_nc_rdata, m_nc);
      if (m_ph == P_BUS) begin
        check("we", o_wb_we, m_kind == K_BW || m_kind == K_NW);
        if (m_kind == K_BR || m_kind == K_BW) begin
          ea = m_addr + 32'(m_beat * LANES);
          es = 4'hF;
          ew = m_bw[m_beat*32 +: 32];
        end else begin
          ea = m_addr - (m_addr % 4);
          es = 4'(((1 << (1 << m_size)) - 1) << m_addr[1:0]);
          ew = m_ncw << (8 * m_addr[1:0]);
        end
        check("wb_addr", o_wb_addr, ea);
        check("wb_sel", o_wb_sel, es);
        if (m_kind == K_BW || m_kind == K_NW) check("wb_wdata", o_wb_wdata, ew);
      end
      if (o_wb_cyc && !prev_cyc) first_addr = o_wb_addr;
      if (o_wb_cyc) begin
        last_addr = o_wb_addr; last_sel = o_wb_sel; last_wdata = o_wb_wdata; cyc_cnt++;
      end
      if (o_done) done_cnt++;
      prev_cyc = o_wb_cyc;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(input string name, output int ncyc, output logic err);
    ncyc = -1;
    err = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (o_done) begin ncyc = c; err = o_err; break; end
    end
    if (ncyc < 0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no o_done expected o_done within 200 cycles", name);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic e;
    i_blk_rd_req = 0; i_blk_wr_req = 0; i_nc_rd_req = 0; i_nc_wr_req = 0;
    i_blk_addr = 0; i_nc_addr = 0; i_nc_size = 0; i_nc_wdata = 0;
    for (int i = 0; i < BEATS; i++) i_blk_wdata[i*32 +: 32] = 32'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", o_wb_cyc, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_blk", o_blk_rdata, '0);
    check("rst_nc", o_nc_rdata, 32'h0);
    arst = 1'b0;
    next_cycle();

    // Refill, zero-wait ack
    rd_base = 32'hA000_0000; ack_period = 1; err_beat = -1;
    i_blk_addr = 32'h1000_0024; i_blk_rd_req = 1;
    wait_done("refill", n, e); i_blk_rd_req = 0;
    check("refill_lat", n, 17);
    check("refill_err", e, 1'b0);
    check("refill_first", first_addr, 32'h1000_0000);
    check("refill_last", last_addr, 32'h1000_003C);
    check("refill_w0", o_blk_rdata[31:0], 32'hA000_0000);
    check("refill_w15", o_blk_rdata[511:480], 32'hA000_000F);
    next_cycle();

    // Write-back with ack every 3rd cycle
    ack_period = 3; done_cnt = 0;
    i_blk_addr = 32'h3000_0000; i_blk_wr_req = 1;
    wait_done("wb", n, e); i_blk_wr_req = 0;
    check("wb_lat", n, 49);
    check("wb_err", e, 1'b0);
    check("wb_last_addr", last_addr, 32'h3000_003C);
    check("wb_last_wdata", last_wdata, 32'h0000_000F);
    next_cycle(); next_cycle();
    check("wb_done_once", done_cnt, 1);
    ack_period = 1;

    // Non-cacheable byte write
    i_nc_addr = 32'h2000_0003; i_nc_size = 2'd0; i_nc_wdata = 32'h5A; i_nc_wr_req = 1;
    wait_done("ncbw", n, e); i_nc_wr_req = 0;
    check("ncbw_lat", n, 2);
    check("ncbw_err", e, 1'b0);
    check("ncbw_addr", last_addr, 32'h2000_0000);
    check("ncbw_sel", last_sel, 4'b1000);
    check("ncbw_wdata", last_wdata, 32'h5A00_0000);
    next_cycle();

    // Non-cacheable half read
    rd_base = 32'hBEEF_1234;
    i_nc_addr = 32'h2000_0002; i_nc_size = 2'd1; i_nc_rd_req = 1;
    wait_done("nchr", n, e); i_nc_rd_req = 0;
    check("nchr_err", e, 1'b0);
    check("nchr_sel", last_sel, 4'b1100);
    check("nchr_data", o_nc_rdata, 32'h0000_BEEF);
    next_cycle();

    // Misaligned word read: no bus cycle
    cyc_cnt = 0;
    i_nc_addr = 32'h2000_0001; i_nc_size = 2'd2; i_nc_rd_req = 1;
    wait_done("mis", n, e); i_nc_rd_req = 0;
    check("mis_lat", n, 1);
    check("mis_err", e, 1'b1);
    check("mis_nocyc", cyc_cnt, 0);
    check("mis_nc_kept", o_nc_rdata, 32'h0000_BEEF);
    next_cycle();

    // Dword on a 32-bit bus is always rejected
    i_nc_addr = 32'h2000_0000; i_nc_size = 2'd3; i_nc_rd_req = 1;
    wait_done("dw", n, e); i_nc_rd_req = 0;
    check("dw_err", e, 1'b1);
    next_cycle();

    // Bus error on beat 5 of a refill
    rd_base = 32'hB000_0000; err_beat = 5;
    i_blk_addr = 32'h1000_0040; i_blk_rd_req = 1;
    wait_done("berr", n, e); i_blk_rd_req = 0;
    err_beat = -1;
    check("berr_lat", n, 7);
    check("berr_err", e, 1'b1);
    check("berr_w0", o_blk_rdata[31:0], 32'hB000_0000);
    check("berr_w4", o_blk_rdata[159:128], 32'hB000_0004);
    check("berr_w5", o_blk_rdata[191:160], 32'hA000_0005);
    next_cycle();

    // Simultaneous blk_rd and nc_wr: block first, then the write
    rd_base = 32'hC000_0000;
    i_blk_addr = 32'h1000_0080; i_blk_rd_req = 1;
    i_nc_addr = 32'h2000_0004; i_nc_size = 2'd2; i_nc_wdata = 32'h1234_5678; i_nc_wr_req = 1;
    wait_done("arb1", n, e); i_blk_rd_req = 0;
    check("arb1_lat", n, 17);
    check("arb1_first", first_addr, 32'h1000_0080);
    wait_done("arb2", n, e); i_nc_wr_req = 0;
    check("arb2_lat", n, 3);
    check("arb2_addr", last_addr, 32'h2000_0004);
    check("arb2_wdata", last_wdata, 32'h1234_5678);
    next_cycle();

    // Reset in the middle of a refill
    done_cnt = 0;
    rd_base = 32'hD000_0000;
    i_blk_addr = 32'h1000_0000; i_blk_rd_req = 1;
    repeat (4) @(posedge clk);
    #2;
    arst = 1'b1; i_blk_rd_req = 0;
    repeat (2) @(posedge clk);
    #1;
    check("mrst_blk", o_blk_rdata, '0);
    check("mrst_cyc", o_wb_cyc, 1'b0);
    arst = 1'b0;
    next_cycle();
    check("mrst_nodone", done_cnt, 0);

    // Recovery: aligned word read
    rd_base = 32'h1357_9BDF;
    i_nc_addr = 32'h2000_0008; i_nc_size = 2'd2; i_nc_rd_req = 1;
    wait_done("rec", n, e); i_nc_rd_req = 0;
    check("rec_lat", n, 2);
    check("rec_data", o_nc_rdata, 32'h1357_9BDF);
    next_cycle(); next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_cache_bridge.md
Name: wb_cache_bridge

Overview:
- Parametrised bridge between the CPU datapath and the Wishbone-style memory bus.
- Serialises cache-block refills and write-backs into BLOCK_WIDTH/DATA_WIDTH single-word beats.
- Performs non-cacheable byte/half/word(/dword) accesses with lane-correct select and data alignment.
- Adds bus-error and misalignment reporting, and one-cycle done/err pulses back to the datapath.

Parameters:
- ADDR_WIDTH, 32, address width of both the datapath and bus sides.
- DATA_WIDTH, 32, bus data width; must be 32 or 64.
- BLOCK_WIDTH, 512, cache block width; integer multiple of DATA_WIDTH, at least 2 beats.
- Derived localparams (not overridable):
  - BEATS = BLOCK_WIDTH/DATA_WIDTH
  - LANES = DATA_WIDTH/8
  - OFFS = log2(LANES)
  - CNT_W = log2(BEATS)

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- i_blk_rd_req  in  1  block refill request; level, held until o_done.
- i_blk_wr_req  in  1  block write-back request; level, held until o_done.
- i_blk_addr  in  ADDR_WIDTH  block address; low log2(BLOCK_WIDTH/8) bits ignored.
- i_blk_wdata  in  BLOCK_WIDTH  write-back block; beat i = [i*DATA_WIDTH +: DATA_WIDTH].
- o_blk_rdata  out  BLOCK_WIDTH  refilled block.
- i_nc_rd_req  in  1  non-cacheable read request; level.
- i_nc_wr_req  in  1  non-cacheable write request; level.
- i_nc_addr  in  ADDR_WIDTH  non-cacheable byte address.
- i_nc_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
- i_nc_wdata  in  DATA_WIDTH  write data, LSB-justified.
- o_nc_rdata  out  DATA_WIDTH  read data, LSB-justified, zero-extended.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  one-cycle error flag, valid only with o_done.
- o_wb_cyc  out  1  bus cycle/strobe.
- o_wb_we  out  1  bus write enable.
- o_wb_sel  out  LANES  byte lane select.
- o_wb_addr  out  ADDR_WIDTH  bus word address (byte addressed, LANES-aligned).
- o_wb_wdata  out  DATA_WIDTH  bus write data.
- i_wb_rdata  in  DATA_WIDTH  bus read data.
- i_wb_ack  in  1  bus acknowledge.
- i_wb_err  in  1  bus error; terminates the beat like ack.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs 0, including o_blk_rdata and o_nc_rdata.
  - Beat counter 0.
  - Reset mid-transfer abandons the bus cycle immediately; no o_done.
- States: IDLE, BLK_RD, BLK_WR, NC_RD, NC_WR, DONE.
- IDLE arbitration, when more than one request is high: blk_wr > blk_rd > nc_wr > nc_rd.
- On accept, capture into registers: address, block write data, size, nc write data, opcode. Inputs may change afterwards.
- Block accept: base = i_blk_addr with the block-offset bits cleared; counter = 0.
- Non-cacheable accept, misalignment check: misaligned when addr modulo 2^size != 0, or when size = 3 and DATA_WIDTH = 32.
  - Misaligned: go to DONE with err = 1. No bus cycle issued.
- Bus states:
  - o_wb_cyc = 1 continuously while in BLK_RD/BLK_WR/NC_RD/NC_WR.
  - o_wb_we = 1 in write states.
- Block beats:
  - o_wb_addr = base + cnt*LANES.
  - o_wb_sel = all ones.
  - o_wb_wdata = beat cnt of the captured block.
- Block acknowledge:
  - On i_wb_ack in BLK_RD, i_wb_rdata is written into o_blk_rdata slice cnt.
  - After any acked beat, cnt increments and the address advances in the next cycle; o_wb_cyc stays high.
  - Ack on beat BEATS-1 goes to DONE with err = 0, and cnt wraps to 0.
- Non-cacheable bus access:
  - o_wb_addr = addr with the low OFFS bits cleared.
  - o_wb_sel = ((1 << 2^size) - 1) << addr[OFFS-1:0].
  - o_wb_wdata = captured wdata << 8*addr[OFFS-1:0].
- Non-cacheable read acknowledge: o_nc_rdata = (i_wb_rdata >> 8*offset), masked to 8*2^size bits; registered on ack.
- Bus error: i_wb_err in any bus state, including simultaneous with ack, ends the transfer and goes to DONE with err = 1.
  - o_blk_rdata keeps the beats received so far.
  - o_nc_rdata is unchanged.
- DONE:
  - o_done = 1 and o_err = err for exactly one cycle, then IDLE.
  - Requests are ignored in DONE.
  - The requester drops its request on seeing o_done; a request still high in the following IDLE cycle starts a new transfer.
- Latency with zero-wait ack (ack in the first cycle o_wb_cyc is high):
  - Non-cacheable: request in cycle 0, bus cycle in cycle 1, o_done in cycle 2.
  - Block: o_done in cycle BEATS+1.
- Output stability: o_blk_rdata and o_nc_rdata hold their values until overwritten by a later transfer.

Decomposition:
- Shared package wb_bridge_pkg holds:
  - the state enum;
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD);
  - a function computing sel from size and offset.
- One sub-module, wb_lane_align: combinational sel, write shift, read shift/mask and misalign flag.

Test Plan:
- Refill, BLOCK_WIDTH 512 / DATA_WIDTH 32:
  - Stimulus: i_blk_rd_req at 0x1000_0024, ack every cycle, rdata = 0xA000_0000+beat.
  - Expect: addresses 0x1000_0000..0x1000_003C; o_blk_rdata[31:0] = 0xA000_0000 and [511:480] = 0xA000_000F; o_done at cycle 17.
- Write-back with wait states:
  - Stimulus: ack every 3rd cycle, block pattern i_blk_wdata[32i+:32] = i.
  - Expect: o_wb_wdata steps 0..15 only after acks; o_wb_cyc never drops; o_done once.
- Non-cacheable byte write:
  - Stimulus: addr 0x2000_0003, size 0, wdata 0x5A.
  - Expect: o_wb_addr 0x2000_0000, sel 4'b1000, wdata 0x5A00_0000; done, err = 0.
- Non-cacheable half read:
  - Stimulus: addr 0x2000_0002, ack with rdata 0xBEEF_1234.
  - Expect: o_nc_rdata 0x0000_BEEF.
- Misaligned word read:
  - Stimulus: addr 0x2000_0001.
  - Expect: no o_wb_cyc; o_done and o_err in cycle 1.
- Error and arbitration:
  - Stimulus: i_wb_err on beat 5 of a refill.
    - Expect: o_done + o_err; beats 0-4 kept.
  - Stimulus: simultaneous blk_rd and nc_wr.
    - Expect: block served first; nc_wr served in the IDLE after that DONE.
